// File: rtl/datapath_pipe_if.sv
// Issue, result and external-write bundle for datapath_pipe.
// The master side drives operations and load data. The slave side is the datapath.
interface datapath_pipe_if #(
  parameter int XLEN = 64,
  parameter int AW   = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   reg_read_addr_1;
  logic [AW-1:0]   reg_read_addr_2;
  logic [AW-1:0]   reg_write_addr;
  logic            reg_write_cmd;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic [7:0]      alu_operation;
  logic            ext_write_cmd;
  logic [AW-1:0]   ext_write_addr;
  logic [XLEN-1:0] ext_write_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_output;
  logic            zero_flag;
  logic            negative_flag;
  logic            overflow_flag;
  logic            carry_flag;
  logic            illegal_op;

  modport master (
    output in_valid, reg_read_addr_1, reg_read_addr_2, reg_write_addr, reg_write_cmd,
           use_imm, imm, alu_operation, ext_write_cmd, ext_write_addr, ext_write_data,
           out_ready,
    input  in_ready, out_valid, alu_output, zero_flag, negative_flag, overflow_flag,
           carry_flag, illegal_op
  );

  modport slave (
    input  in_valid, reg_read_addr_1, reg_read_addr_2, reg_write_addr, reg_write_cmd,
           use_imm, imm, alu_operation, ext_write_cmd, ext_write_addr, ext_write_data,
           out_ready,
    output in_ready, out_valid, alu_output, zero_flag, negative_flag, overflow_flag,
           carry_flag, illegal_op
  );
endinterface

// File: rtl/datapath_pipe.sv
// Two-stage (EX -> WB) register-file + ALU datapath with WB->EX forwarding,
// registered flags and an external load-write port. The whole pipe stalls
// together whenever WB holds a result that the consumer has not taken.
module datapath_pipe #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 256,
  parameter int ZERO_REG = 0
) (
  input  logic           clock,
  input  logic           reset,
  datapath_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);
  localparam bit ZR = (ZERO_REG != 0);

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_SLL  = 8'h05;
  localparam logic [7:0] OP_SRL  = 8'h06;
  localparam logic [7:0] OP_SRA  = 8'h07;
  localparam logic [7:0] OP_SLT  = 8'h08;
  localparam logic [7:0] OP_SLTU = 8'h09;
  localparam logic [7:0] OP_PASS = 8'h0A;

  logic [XLEN-1:0] regs_r [NREGS];

  logic            ex_valid_r;
  logic [AW-1:0]   ex_ra1_r;
  logic [AW-1:0]   ex_ra2_r;
  logic [AW-1:0]   ex_wa_r;
  logic            ex_wcmd_r;
  logic            ex_use_imm_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [7:0]      ex_op_r;

  logic            wb_valid_r;
  logic [XLEN-1:0] wb_result_r;
  logic            wb_zero_r;
  logic            wb_neg_r;
  logic            wb_ovf_r;
  logic            wb_cry_r;
  logic            wb_ill_r;
  logic [AW-1:0]   wb_wa_r;
  logic            wb_wcmd_r;

  logic            stall_s;
  logic            issue_s;
  logic            wb_we_s;
  logic            ext_we_s;
  logic [XLEN-1:0] op_a_s;
  logic [XLEN-1:0] reg_b_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN:0]   add_s;
  logic [XLEN:0]   sub_s;
  logic [SW-1:0]   shamt_s;
  logic [XLEN-1:0] alu_res_s;
  logic            ill_s;
  logic            ovf_s;
  logic            cry_s;

  assign stall_s      = wb_valid_r && !bus.out_ready;
  assign bus.in_ready = !reset && !stall_s;
  assign issue_s      = bus.in_valid && bus.in_ready;

  // WB write only on the firing edge; address 0 is dropped when hard-wired to zero
  assign wb_we_s  = wb_valid_r && bus.out_ready && wb_wcmd_r && !(ZR && (wb_wa_r == {AW{1'b0}}));
  // A same-address WB write on the same edge takes priority over the load port
  assign ext_we_s = bus.ext_write_cmd && !(ZR && (bus.ext_write_addr == {AW{1'b0}}))
                    && !(wb_we_s && (wb_wa_r == bus.ext_write_addr));

  assign bus.out_valid     = wb_valid_r;
  assign bus.alu_output    = wb_result_r;
  assign bus.zero_flag     = wb_zero_r;
  assign bus.negative_flag = wb_neg_r;
  assign bus.overflow_flag = wb_ovf_r;
  assign bus.carry_flag    = wb_cry_r;
  assign bus.illegal_op    = wb_ill_r;

  // Source A: forward a pending WB write, else read the register file
  always_comb begin
    if (wb_valid_r && wb_wcmd_r && (wb_wa_r == ex_ra1_r) && !(ZR && (ex_ra1_r == {AW{1'b0}}))) begin
      op_a_s = wb_result_r;
    end else if (ZR && (ex_ra1_r == {AW{1'b0}})) begin
      op_a_s = {XLEN{1'b0}};
    end else begin
      op_a_s = regs_r[ex_ra1_r];
    end
  end

  // Source B: same forwarding rule, then the immediate overrides when selected
  always_comb begin
    if (wb_valid_r && wb_wcmd_r && (wb_wa_r == ex_ra2_r) && !(ZR && (ex_ra2_r == {AW{1'b0}}))) begin
      reg_b_s = wb_result_r;
    end else if (ZR && (ex_ra2_r == {AW{1'b0}})) begin
      reg_b_s = {XLEN{1'b0}};
    end else begin
      reg_b_s = regs_r[ex_ra2_r];
    end
    if (ex_use_imm_r) begin
      op_b_s = ex_imm_r;
    end else begin
      op_b_s = reg_b_s;
    end
  end

  // ALU: SUB computes A + ~B + 1, so its carry-out is NOT borrow
  always_comb begin
    add_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
    sub_s     = {1'b0, op_a_s} + {1'b0, ~op_b_s} + {{XLEN{1'b0}}, 1'b1};
    shamt_s   = op_b_s[SW-1:0];
    alu_res_s = {XLEN{1'b0}};
    ill_s     = 1'b0;
    ovf_s     = 1'b0;
    cry_s     = 1'b0;
    case (ex_op_r)
      OP_ADD: begin
        alu_res_s = add_s[XLEN-1:0];
        cry_s     = add_s[XLEN];
        ovf_s     = (op_a_s[XLEN-1] == op_b_s[XLEN-1]) && (add_s[XLEN-1] != op_a_s[XLEN-1]);
      end
      OP_SUB: begin
        alu_res_s = sub_s[XLEN-1:0];
        cry_s     = sub_s[XLEN];
        ovf_s     = (op_a_s[XLEN-1] != op_b_s[XLEN-1]) && (sub_s[XLEN-1] != op_a_s[XLEN-1]);
      end
      OP_AND:  alu_res_s = op_a_s & op_b_s;
      OP_OR:   alu_res_s = op_a_s | op_b_s;
      OP_XOR:  alu_res_s = op_a_s ^ op_b_s;
      OP_SLL:  alu_res_s = op_a_s << shamt_s;
      OP_SRL:  alu_res_s = op_a_s >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a_s < op_b_s)};
      OP_PASS: alu_res_s = op_b_s;
      default: ill_s = 1'b1;
    endcase
  end

  // EX/WB pipeline registers; everything holds while WB is stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_r   <= 1'b0;
      ex_ra1_r     <= {AW{1'b0}};
      ex_ra2_r     <= {AW{1'b0}};
      ex_wa_r      <= {AW{1'b0}};
      ex_wcmd_r    <= 1'b0;
      ex_use_imm_r <= 1'b0;
      ex_imm_r     <= {XLEN{1'b0}};
      ex_op_r      <= 8'h00;
      wb_valid_r   <= 1'b0;
      wb_result_r  <= {XLEN{1'b0}};
      wb_zero_r    <= 1'b0;
      wb_neg_r     <= 1'b0;
      wb_ovf_r     <= 1'b0;
      wb_cry_r     <= 1'b0;
      wb_ill_r     <= 1'b0;
      wb_wa_r      <= {AW{1'b0}};
      wb_wcmd_r    <= 1'b0;
    end else if (!stall_s) begin
      ex_valid_r <= issue_s;
      if (issue_s) begin
        ex_ra1_r     <= bus.reg_read_addr_1;
        ex_ra2_r     <= bus.reg_read_addr_2;
        ex_wa_r      <= bus.reg_write_addr;
        ex_wcmd_r    <= bus.reg_write_cmd;
        ex_use_imm_r <= bus.use_imm;
        ex_imm_r     <= bus.imm;
        ex_op_r      <= bus.alu_operation;
      end
      wb_valid_r  <= ex_valid_r;
      wb_result_r <= ex_valid_r ? alu_res_s : {XLEN{1'b0}};
      wb_zero_r   <= ex_valid_r && (alu_res_s == {XLEN{1'b0}});
      wb_neg_r    <= ex_valid_r && alu_res_s[XLEN-1];
      wb_ovf_r    <= ex_valid_r && ovf_s;
      wb_cry_r    <= ex_valid_r && cry_s;
      wb_ill_r    <= ex_valid_r && ill_s;
      wb_wa_r     <= ex_wa_r;
      wb_wcmd_r   <= ex_valid_r && ex_wcmd_r && !ill_s;
    end
  end

  // Register file: load port first so a colliding WB write overrides it
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (ext_we_s) begin
        regs_r[bus.ext_write_addr] <= bus.ext_write_data;
      end
      if (wb_we_s) begin
        regs_r[wb_wa_r] <= wb_result_r;
      end
    end
  end
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised, two-stage pipelined register-file + ALU datapath with a valid/ready issue port, operand forwarding, registered flags, and an external write port for load data. Accepts one operation per cycle, reads two source registers, executes, and writes the result back. Replaces the flat combinational register-file/ALU pairing inside the DJ Core datapath.

## Interface
- `XLEN`, 64: data width in bits.
- `NREGS`, 256: register count. `AW = $clog2(NREGS)` is derived.
- `ZERO_REG`, 0: when 1, register 0 reads as 0 and ignores writes.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  issue request.
- `in_ready`  out  1  issue can be accepted.
- `reg_read_addr_1`  in  AW  source A register.
- `reg_read_addr_2`  in  AW  source B register.
- `reg_write_addr`  in  AW  destination register.
- `reg_write_cmd`  in  1  write result back to the destination.
- `use_imm`  in  1  B operand is `imm` instead of source B.
- `imm`  in  XLEN  immediate operand.
- `alu_operation`  in  8  opcode.
- `ext_write_cmd` / `ext_write_addr` / `ext_write_data`  in  1/AW/XLEN  external (load) write port.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `alu_output`  out  XLEN  result.
- `zero_flag`, `negative_flag`, `overflow_flag`, `carry_flag`, `illegal_op`  out  1 each.

## Operation
- **Handshake.** An issue fires when `in_valid && in_ready`. A result fires when `out_valid && out_ready`.
- **EX stage.** Holds the accepted op.
  - Reads the register file combinationally.
  - Forwards from the WB stage if WB is valid, WB `reg_write_cmd` is 1, and the WB destination equals the source address. With `ZERO_REG=1`, address 0 is never forwarded.
  - Computes the ALU result.
- **WB stage.** Registers the result, flags, destination and write command.
  - The register file is written from WB on the clock edge where the result fires and `reg_write_cmd` is 1.
- **`in_ready`.** Equals `!(out_valid && !out_ready)`, so the whole pipe stalls together. While stalled, the EX and WB contents hold.
- **Opcodes** (the low 8 bits are decoded; `A` = source A, `B` = source B or `imm`):
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 SLL, 0x06 SRL, 0x07 SRA. Shift amount is `B[$clog2(XLEN)-1:0]`.
  - 0x08 SLT (signed), 0x09 SLTU (result 1 or 0).
  - 0x0A PASS_B.
  - Any other code: result 0, `illegal_op`=1, and no register write.
- **Flags:**
  - `zero_flag` = (result == 0).
  - `negative_flag` = result[XLEN-1].
  - `overflow_flag` = signed overflow, for ADD/SUB only (otherwise 0).
  - `carry_flag` = carry-out for ADD, or NOT borrow for SUB (otherwise 0).
- **External write.** Commits on the edge it is asserted.
  - If it targets the same address as a WB write on the same edge, the WB write wins.
  - It is not forwarded. EX sees the new value from the following cycle.
- **`ZERO_REG=1`:** writes to address 0 are dropped from both ports.

## Timing
- **Reset.** Synchronous. While `reset` is high:
  - All registers clear to 0.
  - EX and WB valid bits clear to 0, so `out_valid`=0.
  - `alu_output` and all flags are 0.
  - `in_ready`=0 while `reset` is high, and 1 in the first cycle after reset.
  - Reset mid-operation discards in-flight ops with no register write.
- **Latency.** An op accepted at edge E0 executes in cycle E0..E1. It appears on `out_valid`/`alu_output` after E1. If `out_ready`=1, it is written to the register file at E2.
- **Throughput.** One op per cycle with no bubbles. Back-to-back dependent ops receive the forwarded WB value.
- **Simultaneous events:**
  - A result firing and a new issue on the same edge are both accepted.
  - A stalled WB keeps forwarding its held value to EX.

## Test plan
- **Forwarding.**
  - Setup: ext-write r1=5, r2=7.
  - Stimulus: issue ADD r3=r1+r2, then ADD r4=r3+r1 back-to-back, `out_ready`=1.
  - Expect: outputs 12 then 17 on consecutive cycles. After draining, r4=17.
- **Back-pressure.**
  - Stimulus: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Expect: `in_ready`=0. `alu_output` holds stable. No register write occurs. Ops drain in order once `out_ready` returns to 1.
- **Flags (XLEN=64).**
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → `overflow_flag`=1, `negative_flag`=1, `carry_flag`=0.
  - SUB 5−5 → `zero_flag`=1, `carry_flag`=1.
  - Opcode 0x3F → `illegal_op`=1, destination unchanged.
- **Write collision.**
  - Stimulus: WB result for r9=0xAA fires on the same edge as ext-write r9=0x55.
  - Expect: r9 reads 0xAA.
- **Reset mid-op.**
  - Stimulus: assert `reset` for 1 cycle while EX and WB are valid.
  - Expect: next cycle `out_valid`=0, all outputs and flags 0, and every register reads 0.
- **`ZERO_REG=1`.**
  - Stimulus: ADD r0=r1+r1 with r1=3, then read r0 as source A in ADD r5=r0+r1.
  - Expect: result 3, i.e. r0 reads 0 and is not forwarded.
